// File: rtl/gray_pkg.sv
// Shared Gray-code definitions: FSM encoding, step classes and a reference decoder.
package gray_pkg;

  // Widest word the generic helpers below handle.
  localparam int unsigned GRAY_MAX_W = 32;

  typedef enum logic [1:0] {
    SEED  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    UP   = 2'd1,
    DN   = 2'd2,
    BAD  = 2'd3
  } step_t;

  // Decode the low w bits of a Gray word; bits at and above w are ignored.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g,
                                                     input int unsigned w);
    logic [GRAY_MAX_W-1:0] b;
    logic                  acc;
    b   = '0;
    acc = 1'b0;
    for (int i = int'(GRAY_MAX_W) - 1; i >= 0; i--) begin
      if (i < int'(w)) begin
        acc  = acc ^ g[i];
        b[i] = acc;
      end
    end
    return b;
  endfunction

  // Classify a modular difference between consecutive w-bit binary samples.
  function automatic step_t classify(input logic [GRAY_MAX_W-1:0] delta,
                                     input int unsigned w);
    logic [GRAY_MAX_W-1:0] all_ones;
    all_ones = (GRAY_MAX_W'(1) << w) - GRAY_MAX_W'(1);
    if (delta == '0)
      return HOLD;
    else if (delta == GRAY_MAX_W'(1))
      return UP;
    else if (delta == all_ones)
      return DN;
    else
      return BAD;
  endfunction

endpackage

// File: rtl/gray_step_decoder_gray2bin.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR of all Gray bits at or above it.
module gray2bin #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] g,
  output logic [W-1:0] b
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign b[i] = ^g[W-1:i];
  end

endmodule

// File: rtl/gray_step_decoder.sv
// Receive side of a Gray-coded counter: decodes, classifies each step and tracks position.
module gray_step_decoder
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned POS_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     g_in,
  input  logic                 g_valid,
  input  logic                 err_clr,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 bin_valid,
  output logic                 dir_up,
  output logic                 dir_dn,
  output logic [POS_WIDTH-1:0] pos,
  output logic                 err
);

  logic [WIDTH-1:0]     b_p0;
  logic [WIDTH-1:0]     delta_p0;
  step_t                cls_p0;

  state_t               state_p1, state_nxt;
  logic [WIDTH-1:0]     prev_p1, prev_nxt;
  logic [WIDTH-1:0]     bin_p1, bin_nxt;
  logic                 vld_p1, vld_nxt;
  logic                 up_p1, up_nxt;
  logic                 dn_p1, dn_nxt;
  logic                 err_p1, err_nxt;
  logic [POS_WIDTH-1:0] pos_p1, pos_nxt;

  // ---- stage p0: combinational decode and step classification of the incoming word
  gray2bin #(.W(WIDTH)) u_dec (
    .g (g_in),
    .b (b_p0)
  );

  assign delta_p0 = b_p0 - prev_p1;
  assign cls_p0   = classify(GRAY_MAX_W'(delta_p0), WIDTH);

  // Next-state and next-output decision; pulses default low, everything else holds.
  always_comb begin
    state_nxt = state_p1;
    prev_nxt  = prev_p1;
    bin_nxt   = bin_p1;
    vld_nxt   = 1'b0;
    up_nxt    = 1'b0;
    dn_nxt    = 1'b0;
    err_nxt   = err_p1;
    pos_nxt   = pos_p1;

    case (state_p1)
      SEED: begin
        if (g_valid) begin
          prev_nxt  = b_p0;
          bin_nxt   = b_p0;
          vld_nxt   = 1'b1;
          state_nxt = TRACK;
        end
      end

      TRACK: begin
        if (g_valid) begin
          prev_nxt = b_p0;
          bin_nxt  = b_p0;
          vld_nxt  = 1'b1;
          case (cls_p0)
            UP: begin
              pos_nxt = pos_p1 + POS_WIDTH'(1);
              up_nxt  = 1'b1;
            end
            DN: begin
              pos_nxt = pos_p1 - POS_WIDTH'(1);
              dn_nxt  = 1'b1;
            end
            BAD: begin
              err_nxt   = 1'b1;
              state_nxt = FAULT;
            end
            default: ;
          endcase
        end
      end

      FAULT: begin
        if (err_clr) begin
          // A sample arriving with the clear becomes the new seed right away.
          err_nxt   = 1'b0;
          state_nxt = g_valid ? TRACK : SEED;
        end
        if (g_valid) begin
          prev_nxt = b_p0;
          bin_nxt  = b_p0;
          vld_nxt  = 1'b1;
        end
      end

      default: state_nxt = SEED;
    endcase
  end

  // ---- stage p1: registered state, reference sample and all outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_p1 <= SEED;
      prev_p1  <= '0;
      bin_p1   <= '0;
      vld_p1   <= 1'b0;
      up_p1    <= 1'b0;
      dn_p1    <= 1'b0;
      err_p1   <= 1'b0;
      pos_p1   <= '0;
    end else begin
      state_p1 <= state_nxt;
      prev_p1  <= prev_nxt;
      bin_p1   <= bin_nxt;
      vld_p1   <= vld_nxt;
      up_p1    <= up_nxt;
      dn_p1    <= dn_nxt;
      err_p1   <= err_nxt;
      pos_p1   <= pos_nxt;
    end
  end

  assign bin_out   = bin_p1;
  assign bin_valid = vld_p1;
  assign dir_up    = up_p1;
  assign dir_dn    = dn_p1;
  assign pos       = pos_p1;
  assign err       = err_p1;

endmodule

// File: tb/tb_gray_step_decoder.sv
// Bench for gray_step_decoder: directed scenarios plus randomized steps against a behavioural model.
module tb_gray_step_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  g_in = '0;
  logic        g_valid = 1'b0;
  logic        err_clr = 1'b0;

  logic [3:0]  bin_out, bin_out4;
  logic        bin_valid, bin_valid4;
  logic        dir_up, dir_up4;
  logic        dir_dn, dir_dn4;
  logic [15:0] pos;
  logic [3:0]  pos4;
  logic        err, err4;

  int checks = 0;
  int failures = 0;

  // behavioural model
  bit m_seeded;
  bit m_err;
  int m_prev;
  int m_pos;
  bit e_vld, e_up, e_dn;
  int e_bin;
  int up_count;

  always #5 clk = ~clk;

  gray_step_decoder #(.WIDTH(4), .POS_WIDTH(16)) u_dut (
    .clk(clk), .reset(reset), .g_in(g_in), .g_valid(g_valid), .err_clr(err_clr),
    .bin_out(bin_out), .bin_valid(bin_valid), .dir_up(dir_up), .dir_dn(dir_dn),
    .pos(pos), .err(err)
  );

  gray_step_decoder #(.WIDTH(4), .POS_WIDTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .g_in(g_in), .g_valid(g_valid), .err_clr(err_clr),
    .bin_out(bin_out4), .bin_valid(bin_valid4), .dir_up(dir_up4), .dir_dn(dir_dn4),
    .pos(pos4), .err(err4)
  );

  function automatic int to_gray(input int n);
    return (n ^ (n >> 1)) & 15;
  endfunction

  function automatic int from_gray(input int g);
    return (g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3)) & 15;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":bin_valid"}, 32'(bin_valid), 32'(e_vld));
    chk({tag, ":bin_out"},   32'(bin_out),   32'(e_bin));
    chk({tag, ":dir_up"},    32'(dir_up),    32'(e_up));
    chk({tag, ":dir_dn"},    32'(dir_dn),    32'(e_dn));
    chk({tag, ":pos"},       32'(pos),       32'(m_pos) & 32'hFFFF);
    chk({tag, ":err"},       32'(err),       32'(m_err));
    chk({tag, ":pos4"},      32'(pos4),      32'(m_pos) & 32'hF);
    chk({tag, ":err4"},      32'(err4),      32'(m_err));
    chk({tag, ":dir4"},      32'({dir_up4, dir_dn4, bin_valid4}), 32'({e_up, e_dn, e_vld}));
    chk({tag, ":bin4"},      32'(bin_out4),  32'(e_bin));
  endtask

  function automatic void model_step(input int g, input bit v, input bit clr);
    int b, d;
    e_vld = 0; e_up = 0; e_dn = 0;
    if (m_err && clr) begin
      m_err = 0;
      m_seeded = 0;
    end
    if (v) begin
      b = from_gray(g);
      e_vld = 1;
      e_bin = b;
      if (!m_seeded) m_seeded = 1;
      else if (!m_err) begin
        d = (b - m_prev + 16) % 16;
        if (d == 1) begin m_pos++; e_up = 1; end
        else if (d == 15) begin m_pos--; e_dn = 1; end
        else if (d != 0) m_err = 1;
      end
      m_prev = b;
    end
  endfunction

  task automatic step(input int g, input bit v, input bit clr, input string tag);
    g_in = 4'(g); g_valid = v; err_clr = clr;
    @(posedge clk);
    model_step(g, v, clr);
    #1;
    if (dir_up) up_count++;
    check_all(tag);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before the next edge.
  task automatic do_reset(input string tag);
    #2 reset = 1'b0;
    m_seeded = 0; m_err = 0; m_prev = 0; m_pos = 0;
    e_vld = 0; e_up = 0; e_dn = 0; e_bin = 0;
    #1 check_all(tag);
    #2 reset = 1'b1;
    g_valid = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    int g, b, r;
    bit v, c;

    // 1. reset and seed
    @(posedge clk); #1;
    do_reset("reset");
    step(0, 1, 0, "seed0");

    // 2. full up sequence with wrap; 16-bit pos reaches 16, 4-bit pos wraps to 0
    up_count = 0;
    for (int n = 1; n <= 16; n++) step(to_gray(n % 16), 1, 0, "up_seq");
    chk("up_pulses", 32'(up_count), 32'd16);
    chk("up_pos16", 32'(pos), 32'd16);
    chk("up_pos4", 32'(pos4), 32'd0);

    // 3. down steps across the wrap
    do_reset("reset3");
    step(4'b0000, 1, 0, "seed3");
    step(4'b1000, 1, 0, "dn1");
    step(4'b1001, 1, 0, "dn2");
    chk("dn_pos", 32'(pos), 32'hFFFE);

    // 4. illegal jump, frozen position, clear with same-cycle seed
    do_reset("reset4");
    step(4'b0000, 1, 0, "seed4");
    step(4'b0011, 1, 0, "jump");
    step(4'b0010, 1, 0, "frozen1");
    step(4'b0110, 1, 0, "frozen2");
    step(4'b0011, 1, 1, "clr_seed");
    step(4'b0010, 1, 0, "after_clr");
    chk("after_clr_pos", 32'(pos), 32'd1);

    // 5. repeated samples and valid gaps
    for (int k = 0; k < 3; k++) step(4'b0110, 1, 0, "repeat");
    for (int k = 0; k < 3; k++) step(int'($urandom_range(0, 15)), 0, 0, "gap");

    // 6. reset in the middle of an up run, then re-seed
    for (int n = 5; n < 12; n++) step(to_gray(n), 1, 0, "pre_rst");
    do_reset("mid_reset");
    step(4'b0111, 1, 0, "reseed");
    step(4'b0101, 1, 0, "post_rst_up");

    // randomized: mostly legal steps, some jumps, gaps and clears
    for (int k = 0; k < 400; k++) begin
      r = int'($urandom_range(0, 99));
      b = m_prev;
      if (r < 35)      b = (m_prev + 1) % 16;
      else if (r < 65) b = (m_prev + 15) % 16;
      else if (r < 80) b = m_prev;
      else             b = int'($urandom_range(0, 15));
      g = to_gray(b);
      v = ($urandom_range(0, 9) != 0);
      c = ($urandom_range(0, 7) == 0);
      step(g, v, c, "rand");
      if (k == 200) do_reset("rand_reset");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
